// File: rtl/btn_event_ctrl.sv
// Button event controller: press/auto-repeat detection, per-button pending latch,
// round-robin arbitration into a first-word fall-through event FIFO.
module btn_event_ctrl #(
  parameter int          N_BTN      = 5,
  parameter int          FIFO_DEPTH = 4,
  parameter int unsigned REPEAT_DLY = 50000000,
  parameter int unsigned REPEAT_PER = 10000000,
  localparam int         IDW        = $clog2(N_BTN)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_BTN-1:0] BTN_I,
  output logic             EVT_VALID,
  output logic [IDW-1:0]   EVT_ID,
  output logic             EVT_REP,
  input  logic             EVT_READY,
  output logic [N_BTN-1:0] PENDING_O,
  output logic             DROP_O,
  input  logic             CLR_DROP
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] DLY_LOAD = 32'(REPEAT_DLY - 1);
  localparam logic [31:0] PER_LOAD = 32'(REPEAT_PER - 1);

  logic [N_BTN-1:0]          btn_q;
  logic [N_BTN-1:0]          press;
  logic [N_BTN-1:0]          rep_fire;
  logic [N_BTN-1:0]          evt;
  logic [N_BTN-1:0]          drop_vec;
  logic [N_BTN-1:0]          pending;
  logic [N_BTN-1:0]          rep_flag;
  logic [N_BTN-1:0]          grant_vec;
  logic [N_BTN-1:0][31:0]    rep_cnt;
  logic [IDW-1:0]            rr_ptr;
  logic [IDW-1:0]            grant_id;
  logic                      grant_ok;
  logic [FIFO_DEPTH-1:0][IDW:0] mem;
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [AW:0]               count;
  logic                      pop;
  logic                      can_push;

  // Repeat timer is a down-counter: loaded on press, fires at terminal count 0.
  always_comb begin
    press    = BTN_I & ~btn_q;
    rep_fire = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rep_fire[i] = (REPEAT_DLY != 0) && BTN_I[i] && !press[i] && (rep_cnt[i] == 32'd0);
    end
    evt      = press | rep_fire;
    drop_vec = evt & pending & ~grant_vec;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      btn_q   <= '0;
      rep_cnt <= '0;
    end else begin
      btn_q <= BTN_I;
      for (int i = 0; i < N_BTN; i++) begin
        if (press[i])
          rep_cnt[i] <= DLY_LOAD;
        else if (!BTN_I[i])
          rep_cnt[i] <= '0;
        else if (rep_fire[i])
          rep_cnt[i] <= PER_LOAD;
        else if (rep_cnt[i] != 32'd0)
          rep_cnt[i] <= rep_cnt[i] - 32'd1;
      end
    end
  end

  assign pop      = EVT_VALID & EVT_READY;
  assign can_push = (count != (AW+1)'(FIFO_DEPTH)) | pop;

  always_comb begin
    int idx;
    grant_vec = '0;
    grant_id  = '0;
    grant_ok  = 1'b0;
    idx       = 0;
    if (can_push) begin
      for (int o = 0; o < N_BTN; o++) begin
        idx = (int'(rr_ptr) + o) % N_BTN;
        if (!grant_ok && pending[idx]) begin
          grant_ok       = 1'b1;
          grant_id       = IDW'(idx);
          grant_vec[idx] = 1'b1;
        end
      end
    end
  end

  // A new event wins over a same-cycle grant clear; the old event is already being queued.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pending  <= '0;
      rep_flag <= '0;
      DROP_O   <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (evt[i] && !drop_vec[i]) begin
          pending[i]  <= 1'b1;
          rep_flag[i] <= rep_fire[i];
        end else if (grant_vec[i]) begin
          pending[i] <= 1'b0;
        end
      end
      if (|drop_vec)
        DROP_O <= 1'b1;
      else if (CLR_DROP)
        DROP_O <= 1'b0;
      if (grant_ok)
        rr_ptr <= (grant_id == IDW'(N_BTN - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (grant_ok) begin
        mem[wr_ptr] <= {rep_flag[grant_id], grant_id};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({grant_ok, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign EVT_VALID = (count != '0);
  assign EVT_ID    = mem[rd_ptr][IDW-1:0];
  assign EVT_REP   = mem[rd_ptr][IDW];
  assign PENDING_O = pending;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Bench for btn_event_ctrl: directed scenarios plus random stimulus, all checked
// every cycle against an event-level reference model (hold age, pending set, queue).
module tb_btn_event_ctrl;
  localparam int N   = 5;
  localparam int DEP = 4;
  localparam int D   = 20;
  localparam int P   = 5;
  localparam int IDW = 3;

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   BTN_I;
  logic           EVT_VALID;
  logic [IDW-1:0] EVT_ID;
  logic           EVT_REP;
  logic           EVT_READY;
  logic [N-1:0]   PENDING_O;
  logic           DROP_O;
  logic           CLR_DROP;

  btn_event_ctrl #(.N_BTN(N), .FIFO_DEPTH(DEP), .REPEAT_DLY(D), .REPEAT_PER(P)) dut (
    .CLK(CLK), .RST(RST), .BTN_I(BTN_I), .EVT_VALID(EVT_VALID), .EVT_ID(EVT_ID),
    .EVT_REP(EVT_REP), .EVT_READY(EVT_READY), .PENDING_O(PENDING_O),
    .DROP_O(DROP_O), .CLR_DROP(CLR_DROP)
  );

  always #5 CLK = ~CLK;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state; queue entries are rep*8 + id
  bit [N-1:0] m_prev, m_pend, m_rep;
  int         m_age[N];
  int         m_rr;
  bit         m_drop;
  int         m_q[$];
  int         got[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit pop, fire, prs, drop_set;
    int g;
    if (RST) begin
      m_prev = '0; m_pend = '0; m_rep = '0; m_rr = 0; m_drop = 0;
      m_q.delete();
      for (int i = 0; i < N; i++) m_age[i] = 0;
      return;
    end
    pop = (m_q.size() > 0) && EVT_READY;
    g = -1;
    if (m_q.size() - (pop ? 1 : 0) < DEP)
      for (int o = 0; o < N; o++)
        if (g < 0 && m_pend[(m_rr + o) % N]) g = (m_rr + o) % N;
    if (pop) void'(m_q.pop_front());
    if (g >= 0) begin
      m_q.push_back(m_rep[g] * 8 + g);
      m_rr = (g + 1) % N;
    end
    drop_set = 0;
    for (int i = 0; i < N; i++) begin
      prs = BTN_I[i] && !m_prev[i];
      if (prs) m_age[i] = 0;
      else if (BTN_I[i]) m_age[i]++;
      else m_age[i] = 0;
      fire = !prs && BTN_I[i] && m_age[i] >= D && ((m_age[i] - D) % P == 0);
      if (prs || fire) begin
        if (m_pend[i] && g != i) drop_set = 1;
        else begin m_pend[i] = 1; m_rep[i] = fire; end
      end else if (g == i) m_pend[i] = 0;
    end
    if (drop_set) m_drop = 1;
    else if (CLR_DROP) m_drop = 0;
    m_prev = BTN_I;
  endtask

  task automatic check_all();
    chk("valid", EVT_VALID, m_q.size() != 0);
    chk("pending", PENDING_O, m_pend);
    chk("drop", DROP_O, m_drop);
    if (m_q.size() != 0) begin
      chk("id", EVT_ID, m_q[0] % 8);
      chk("rep", EVT_REP, m_q[0] / 8);
    end
  endtask

  task automatic step();
    if (EVT_VALID && EVT_READY && !RST) got.push_back(int'({EVT_REP, EVT_ID}));
    @(posedge CLK);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    RST = 1; BTN_I = '0; CLR_DROP = 0;
    step();
    RST = 0;
  endtask

  initial begin
    RST = 1; BTN_I = '0; EVT_READY = 0; CLR_DROP = 0;
    step(); step();
    chk("rst_valid", EVT_VALID, 0);
    chk("rst_id", EVT_ID, 0);
    chk("rst_rep", EVT_REP, 0);
    chk("rst_pend", PENDING_O, 0);
    chk("rst_drop", DROP_O, 0);
    RST = 0;

    // Single press: visible for exactly one cycle after edge k+1
    EVT_READY = 1;
    BTN_I = 5'b00100;
    step();
    chk("s1_pend_k", PENDING_O, 5'b00100);
    step();
    chk("s1_valid", EVT_VALID, 1);
    chk("s1_id", EVT_ID, 2);
    chk("s1_rep", EVT_REP, 0);
    step();
    chk("s1_one_cycle", EVT_VALID, 0);
    chk("s1_drop", DROP_O, 0);
    BTN_I = '0;
    step();

    // Simultaneous presses drain in round-robin order
    do_reset();
    got.delete();
    EVT_READY = 1;
    BTN_I = 5'b10101;
    for (int c = 0; c < 6; c++) step();
    BTN_I = '0;
    step(); step();
    chk("s2_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("s2_ev0", got[0], 0);
      chk("s2_ev1", got[1], 2);
      chk("s2_ev2", got[2], 4);
    end

    // Back-pressure: FIFO fills, last button waits in pending
    do_reset();
    got.delete();
    EVT_READY = 0;
    for (int b = 0; b < N; b++) begin
      BTN_I[b] = 1'b1;
      step();
    end
    step(); step();
    chk("s3_pend", PENDING_O, 5'b10000);
    chk("s3_drop", DROP_O, 0);
    chk("s3_head", EVT_ID, 0);
    EVT_READY = 1;
    for (int c = 0; c < 7; c++) step();
    BTN_I = '0;
    step();
    chk("s3_count", got.size(), 5);
    if (got.size() == 5)
      for (int i = 0; i < 5; i++) chk("s3_order", got[i], i);

    // Auto-repeat: 32-cycle hold gives one press and three repeats
    do_reset();
    got.delete();
    EVT_READY = 1;
    BTN_I = 5'b00010;
    for (int c = 0; c < 32; c++) step();
    BTN_I = '0;
    for (int c = 0; c < 10; c++) step();
    chk("s4_count", got.size(), 4);
    if (got.size() == 4) begin
      chk("s4_press", got[0], 1);
      for (int i = 1; i < 4; i++) chk("s4_repeat", got[i], 9);
    end

    // Drop on re-press while pending, clear, then reset mid-burst
    do_reset();
    EVT_READY = 0;
    BTN_I = 5'b10111;
    for (int c = 0; c < 5; c++) step();
    BTN_I[3] = 1'b1;
    step();
    BTN_I[3] = 1'b0;
    step();
    BTN_I[3] = 1'b1;
    step();
    chk("s5_drop_set", DROP_O, 1);
    chk("s5_pend3", PENDING_O[3], 1);
    CLR_DROP = 1;
    step();
    CLR_DROP = 0;
    chk("s5_drop_clr", DROP_O, 0);
    RST = 1;
    step();
    chk("s5_rst_valid", EVT_VALID, 0);
    chk("s5_rst_pend", PENDING_O, 0);
    RST = 0;
    BTN_I = '0;
    step();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range((c < 1500) ? 15 : 47) == 0) BTN_I[b] = ~BTN_I[b];
      EVT_READY = ((c % 200) < 60) ? 1'b0 : ($urandom_range(3) != 0);
      CLR_DROP  = ($urandom_range(31) == 0);
      RST       = ($urandom_range(499) == 0);
      step();
    end
    RST = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
